// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the two-requester block-RAM burst arbiter.
// Holds the FSM state encoding, width defaults and a requester-index to one-hot helper.
package bram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int ADDR_W_DFLT = 8;
  localparam int DATA_W_DFLT = 32;
  localparam int LEN_W_DFLT  = 8;
  localparam int NUM_REQ     = 2;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational: on a tie the requester that
// did not own the RAM last time wins.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    if (i_req == 2'b11) begin
      o_winner = ~i_last_owner;
    end else if (i_req[1]) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/bram_burst_arbiter.sv
// Round-robin sharing of one 1-cycle-latency block RAM between two requesters: single writes, 1..255-word reads.
// Grant one cycle after an IDLE sample, one beat per cycle, read data one cycle after its beat; requests wait while busy.
module bram_burst_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int LEN_W  = LEN_W_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]   len_i,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_rden,
  output logic                       mem_wren,
  input  logic [DATA_W-1:0]          mem_rdata
);

  state_t              r_state;
  logic                r_owner;
  logic                r_last_owner;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_beat;
  logic [LEN_W-1:0]    r_last_beat;
  logic [DATA_W-1:0]   r_wdata;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [NUM_REQ-1:0]  r_done;

  state_t              w_state_nxt;
  logic                w_take;
  logic                w_last;
  logic                w_win;
  logic                w_win_vld;
  logic                w_sel_rw;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [LEN_W-1:0]    w_sel_last_beat;

  rr_arbiter2 u_rr (
    .i_req        (req_i),
    .i_last_owner (r_last_owner),
    .o_winner     (w_win),
    .o_valid      (w_win_vld)
  );

  assign w_sel_rw    = w_win ? rw_i[1] : rw_i[0];
  assign w_sel_addr  = w_win ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
  assign w_sel_len   = w_win ? len_i[2*LEN_W-1:LEN_W]    : len_i[LEN_W-1:0];
  assign w_sel_wdata = w_win ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];

  // Length 0 is served as a single beat; writes are always one beat.
  always_comb begin
    w_sel_last_beat = '0;
    if (w_sel_rw && (w_sel_len != '0)) begin
      w_sel_last_beat = w_sel_len - LEN_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_take      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_beat == r_last_beat) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_rw         <= 1'b0;
      r_base       <= '0;
      r_beat       <= '0;
      r_last_beat  <= '0;
      r_wdata      <= '0;
      r_gnt        <= '0;
      r_rvalid     <= '0;
      r_done       <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_take ? req_onehot(w_win) : '0;
      r_done   <= w_last ? req_onehot(r_owner) : '0;
      r_rvalid <= mem_rden ? req_onehot(r_owner) : '0;
      if (w_take) begin
        r_owner      <= w_win;
        r_last_owner <= w_win;
        r_rw         <= w_sel_rw;
        r_base       <= w_sel_addr;
        r_beat       <= '0;
        r_last_beat  <= w_sel_last_beat;
        r_wdata      <= w_sel_rw ? '0 : w_sel_wdata;
      end else if (r_state == BUSY) begin
        r_beat <= r_beat + LEN_W'(1);
      end
    end
  end

  // RAM strobes come only from registered state, never from the request inputs.
  assign mem_rden  = (r_state == BUSY) &&  r_rw;
  assign mem_wren  = (r_state == BUSY) && !r_rw;
  assign mem_addr  = r_base + ADDR_W'(r_beat);
  assign mem_wdata = mem_wren ? r_wdata : '0;

  assign gnt_o    = r_gnt;
  assign done_o   = r_done;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = (|r_rvalid) ? mem_rdata : '0;
  assign busy_o   = (r_state == BUSY) || (|r_rvalid);

endmodule
